// File: rtl/mpu_elementwise_engine_pkg.sv
// mpu_pkg: op codes, FSM states and slice helpers shared by MPU blocks
package mpu_pkg;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_RSUB = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction
  function automatic int row_lsb(input int i, input int n, input int w);
    return i * n * w;
  endfunction
endpackage

// File: rtl/mpu_elementwise_engine_if.sv
// mpu_elementwise_engine_if: start/done request and matrix operand/result bus
interface mpu_elementwise_engine_if #(parameter int N = 5, parameter int W = 8);
  logic             start;
  logic [1:0]       op;
  logic [N*N*W-1:0] matrix_a;
  logic [N*N*W-1:0] matrix_b;
  logic             busy;
  logic             done;
  logic [N*N*W-1:0] result;
  logic             overflow;
  modport master(output start, op, matrix_a, matrix_b, input busy, done, result, overflow);
  modport slave(input start, op, matrix_a, matrix_b, output busy, done, result, overflow);
endinterface

// File: rtl/mpu_elementwise_engine_row_alu.sv
// mpu_row_alu: N-lane signed add/sub of one matrix row; clamps on overflow when MPU_SATURATE_EN is defined
module mpu_row_alu import mpu_pkg::*; #(parameter int N = 5, parameter int W = 8) (
  input  logic [N*W-1:0] i_row_a,
  input  logic [N*W-1:0] i_row_b,
  input  logic [1:0]     i_op,
  output logic [N*W-1:0] o_row_out,
  output logic [N-1:0]   o_lane_ovf
);
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [W-1:0] w_x, w_y;
    logic [W:0]   w_sum;
    assign w_x = i_op == OP_RSUB ? i_row_b[elem_lsb(0, g, N, W) +: W] : i_row_a[elem_lsb(0, g, N, W) +: W];
    assign w_y = i_op == OP_RSUB ? i_row_a[elem_lsb(0, g, N, W) +: W] : i_row_b[elem_lsb(0, g, N, W) +: W];
    assign w_sum = i_op == OP_ADD ? {w_x[W-1], w_x} + {w_y[W-1], w_y} : {w_x[W-1], w_x} - {w_y[W-1], w_y};
    assign o_lane_ovf[g] = w_sum[W] ^ w_sum[W-1];
`ifdef MPU_SATURATE_EN
    assign o_row_out[elem_lsb(0, g, N, W) +: W] = o_lane_ovf[g] ? {w_sum[W], {(W-1){~w_sum[W]}}} : w_sum[W-1:0];
`else
    assign o_row_out[elem_lsb(0, g, N, W) +: W] = w_sum[W-1:0];
`endif
  end
endmodule

// File: rtl/mpu_elementwise_engine.sv
// mpu_elementwise_engine: row-sequential N x N element-wise add/sub; optional clamping via MPU_SATURATE_EN
module mpu_elementwise_engine import mpu_pkg::*; #(parameter int N = 5, parameter int W = 8) (
  input logic                     clock,
  input logic                     reset,
  mpu_elementwise_engine_if.slave bus
);
  localparam int RW = $clog2(N);
  state_t           r_state, w_next;
  logic [RW-1:0]    r_row;
  logic [1:0]       r_op;
  logic             r_ovf;
  logic [N*N*W-1:0] r_a, r_b, r_result;
  logic [N*W-1:0]   w_row_a, w_row_b, w_row_out;
  logic [N-1:0]     w_lane_ovf;
  // select the latched operand row currently being processed
  always_comb begin
    w_row_a = '0;
    w_row_b = '0;
    for (int i = 0; i < N; i++) begin
      w_row_a = r_row == RW'(i) ? r_a[row_lsb(i, N, W) +: N*W] : w_row_a;
      w_row_b = r_row == RW'(i) ? r_b[row_lsb(i, N, W) +: N*W] : w_row_b;
    end
  end
  mpu_row_alu #(.N(N), .W(W)) u_alu (
    .i_row_a   (w_row_a),
    .i_row_b   (w_row_b),
    .i_op      (r_op),
    .o_row_out (w_row_out),
    .o_lane_ovf(w_lane_ovf)
  );
  // next state: accept in IDLE, walk rows in RUN, single DONE cycle
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE ? (bus.start ? ST_RUN : ST_IDLE) :
             r_state == ST_RUN  ? (r_row == RW'(N-1) ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  // operand latch on accept; per-row result write and sticky overflow while running
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_row    <= '0;
      r_op     <= OP_ADD;
      r_ovf    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_row <= '0;
      r_op  <= bus.op;
      r_ovf <= 1'b0;
      r_a   <= bus.matrix_a;
      r_b   <= bus.matrix_b;
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < N; i++)
        if (r_row == RW'(i)) r_result[row_lsb(i, N, W) +: N*W] <= w_row_out;
      r_ovf <= r_ovf | (|w_lane_ovf);
      r_row <= r_row + 1'b1;
    end
  assign bus.busy     = r_state == ST_RUN;
  assign bus.done     = r_state == ST_DONE;
  assign bus.result   = r_result;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_mpu_elementwise_engine.sv
// tb_mpu_elementwise_engine: directed vectors checked against an integer-arithmetic model every cycle
module tb_mpu_elementwise_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mpu_elementwise_engine_if #(.N(5), .W(8))  bus();
  mpu_elementwise_engine_if #(.N(2), .W(16)) bus2();
  mpu_elementwise_engine #(.N(5), .W(8))  dut (.clock(clock), .reset(reset), .bus(bus));
  mpu_elementwise_engine #(.N(2), .W(16)) dut2(.clock(clock), .reset(reset), .bus(bus2));
  int checks = 0;
  int errors = 0;
  int m_phase = 0;
  logic [199:0] m_res = '0;
  logic m_ovf = 1'b0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [200:0] golden(input logic [199:0] a, input logic [199:0] b, input logic [1:0] op);
    logic [199:0] r;
    logic ov;
    int x, y, s;
    r = '0;
    ov = 1'b0;
    for (int e = 0; e < 25; e++) begin
      x = $signed(a[e*8 +: 8]);
      y = $signed(b[e*8 +: 8]);
      s = op == 2'b00 ? x + y : op == 2'b10 ? y - x : x - y;
      if (s > 127 || s < -128) begin
        ov = 1'b1;
`ifdef MPU_SATURATE_EN
        s = s > 127 ? 127 : -128;
`endif
      end
      r[e*8 +: 8] = s[7:0];
    end
    return {ov, r};
  endfunction
  always @(posedge clock or posedge reset)
    if (reset) m_phase <= 0;
    else if (m_phase == 0) begin
      if (bus.start) begin
        {m_ovf, m_res} <= golden(bus.matrix_a, bus.matrix_b, bus.op);
        m_phase <= 1;
      end
    end else m_phase <= m_phase == 6 ? 0 : m_phase + 1;
  always @(negedge clock) begin
    chk("busy", 256'(bus.busy), 256'(m_phase >= 1 && m_phase <= 5));
    chk("done", 256'(bus.done), 256'(m_phase == 6));
    if (m_phase == 6) begin
      chk("result", 256'(bus.result), 256'(m_res));
      chk("overflow", 256'(bus.overflow), 256'(m_ovf));
    end
  end
  task automatic start_op(input logic [199:0] a, input logic [199:0] b, input logic [1:0] op);
    @(negedge clock);
    bus.matrix_a = a;
    bus.matrix_b = b;
    bus.op = op;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (n < 20) begin
      @(negedge clock);
      if (bus.done) break;
      @(posedge clock);
      n++;
    end
  endtask
  initial begin
    logic [199:0] a, b;
    logic [7:0] e00, e11;
    int lat, dones;
    bus.start = 1'b0; bus.op = 2'b00; bus.matrix_a = '0; bus.matrix_b = '0;
    bus2.start = 1'b0; bus2.op = 2'b00; bus2.matrix_a = '0; bus2.matrix_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_ovf", 256'(bus.overflow), 256'(0));
    chk("rst_result", 256'(bus.result), 256'(0));
    chk("rst_result2", 256'(bus2.result), 256'(0));
    @(negedge clock) reset = 1'b0;
    // 1: SUB 5-3 everywhere
    start_op({25{8'h05}}, {25{8'h03}}, 2'b01);
    wait_done(lat);
    chk("t1_latency", 256'(lat), 256'(6));
    chk("t1_result", 256'(bus.result), 256'({25{8'h02}}));
    chk("t1_ovf", 256'(bus.overflow), 256'(0));
    // 2: RSUB with ramp A
    for (int i = 0; i < 25; i++) a[i*8 +: 8] = 8'(i);
    start_op(a, {25{8'h01}}, 2'b10);
    wait_done(lat);
    chk("t2_e44", 256'(bus.result[199:192]), 256'(8'hE9));
    chk("t2_e00", 256'(bus.result[7:0]), 256'(8'h01));
    chk("t2_e01", 256'(bus.result[15:8]), 256'(8'h00));
    // 3: signed overflow in both directions
`ifdef MPU_SATURATE_EN
    e00 = 8'h7F; e11 = 8'h80;
`else
    e00 = 8'h80; e11 = 8'h7F;
`endif
    a = '0; b = '0;
    a[7:0] = 8'h7F; b[7:0] = 8'h01;
    a[55:48] = 8'h80; b[55:48] = 8'h01;
    start_op(a, b, 2'b00);
    wait_done(lat);
    chk("t3_add_ovf", 256'(bus.overflow), 256'(1));
    chk("t3_add_e00", 256'(bus.result[7:0]), 256'(e00));
    chk("t3_add_e11", 256'(bus.result[55:48]), 256'(8'h81));
    start_op(a, b, 2'b01);
    wait_done(lat);
    chk("t3_sub_ovf", 256'(bus.overflow), 256'(1));
    chk("t3_sub_e11", 256'(bus.result[55:48]), 256'(e11));
    chk("t3_sub_e00", 256'(bus.result[7:0]), 256'(8'h7E));
    start_op(a, b, 2'b11);
    wait_done(lat);
    chk("t3_rsv_e11", 256'(bus.result[55:48]), 256'(e11));
    // 4: start during RUN and during DONE is ignored
    start_op({25{8'h10}}, {25{8'h04}}, 2'b00);
    @(posedge clock);
    @(negedge clock);
    bus.matrix_a = {25{8'h40}};
    bus.op = 2'b10;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_done(lat);
    chk("t4_done_seen", 256'(bus.done), 256'(1));
    chk("t4_result", 256'(bus.result), 256'({25{8'h14}}));
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done || bus.busy) dones++;
    end
    chk("t4_no_restart", 256'(dones), 256'(0));
    // 5: reset on third RUN cycle
    start_op({25{8'h7F}}, {25{8'h01}}, 2'b00);
    repeat (2) @(posedge clock);
    #1 chk("t5_pre_ovf", 256'(bus.overflow), 256'(1));
    #1 reset = 1'b1;
    #1;
    chk("t5_busy", 256'(bus.busy), 256'(0));
    chk("t5_done", 256'(bus.done), 256'(0));
    chk("t5_ovf", 256'(bus.overflow), 256'(0));
    chk("t5_result", 256'(bus.result), 256'(0));
    @(negedge clock) reset = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    chk("t5_no_done", 256'(dones), 256'(0));
    start_op({25{8'h05}}, {25{8'h03}}, 2'b01);
    wait_done(lat);
    chk("t5_latency", 256'(lat), 256'(6));
    chk("t5_result_after", 256'(bus.result), 256'({25{8'h02}}));
    // 6: N=2, W=16 instance
    @(negedge clock);
    bus2.matrix_a = {4{16'h1234}};
    bus2.matrix_b = {4{16'h0101}};
    bus2.op = 2'b00;
    bus2.start = 1'b1;
    @(posedge clock);
    #1 bus2.start = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clock);
      if (bus2.done) break;
      @(posedge clock);
      lat++;
    end
    chk("t6_latency", 256'(lat), 256'(3));
    chk("t6_result", 256'(bus2.result), 256'({4{16'h1335}}));
    chk("t6_ovf", 256'(bus2.overflow), 256'(0));
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
